// File: rtl/axi_master_port.sv
// AXI master-side initiator: converts one client request (single or burst,
// read or write) into AW/W/B or AR/R transactions, one at a time.

`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

module axi_master_port #(
  parameter logic [`AXI_ID_BITS-1:0] MASTER_ID  = '0,
  parameter logic [1:0]              BURST_TYPE = 2'b01
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  // client request
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [`AXI_ADDR_BITS-1:0] req_addr,
  input  logic [`AXI_LEN_BITS-1:0]  req_len,
  input  logic [`AXI_SIZE_BITS-1:0] req_size,
  // client write-data stream
  input  logic                      wd_valid,
  output logic                      wd_ready,
  input  logic [`AXI_DATA_BITS-1:0] wd_data,
  input  logic [`AXI_STRB_BITS-1:0] wd_strb,
  // client read-data stream
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [`AXI_DATA_BITS-1:0] rd_data,
  output logic                      rd_last,
  // completion
  output logic                      done_valid,
  output logic                      done_err,
  // AXI write address
  output logic [`AXI_ID_BITS-1:0]   AWID,
  output logic [`AXI_ADDR_BITS-1:0] AWADDR,
  output logic [`AXI_LEN_BITS-1:0]  AWLEN,
  output logic [`AXI_SIZE_BITS-1:0] AWSIZE,
  output logic [1:0]                AWBURST,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  // AXI write data
  output logic [`AXI_DATA_BITS-1:0] WDATA,
  output logic [`AXI_STRB_BITS-1:0] WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  // AXI write response
  input  logic [`AXI_ID_BITS-1:0]   BID,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  // AXI read address
  output logic [`AXI_ID_BITS-1:0]   ARID,
  output logic [`AXI_ADDR_BITS-1:0] ARADDR,
  output logic [`AXI_LEN_BITS-1:0]  ARLEN,
  output logic [`AXI_SIZE_BITS-1:0] ARSIZE,
  output logic [1:0]                ARBURST,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  // AXI read data
  input  logic [`AXI_ID_BITS-1:0]   RID,
  input  logic [`AXI_DATA_BITS-1:0] RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t                    state, state_nxt;
  logic [`AXI_ADDR_BITS-1:0] addr_q;
  logic [`AXI_LEN_BITS-1:0]  len_q;
  logic [`AXI_SIZE_BITS-1:0] size_q;
  logic [`AXI_LEN_BITS-1:0]  cnt, cnt_nxt;
  logic                      err, err_nxt;
  logic                      last_cnt;

  // The address channels carry the latched request; they are only qualified
  // by VALID, so holding them in registers keeps them stable during AR/AW.
  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = size_q;
  assign AWBURST = BURST_TYPE;
  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = size_q;
  assign ARBURST = BURST_TYPE;
  assign WDATA   = wd_data;
  assign WSTRB   = wd_strb;
  assign rd_data = RDATA;
  assign last_cnt = (cnt == len_q);

  // State, beat counter, error flag and latched request registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      err    <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
      if (state == S_IDLE && req_valid) begin
        addr_q <= req_addr;
        len_q  <= req_len;
        size_q <= req_size;
      end
    end
  end

  // Next-state, counter/error update and handshake outputs per state.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    err_nxt    = err;
    req_ready  = 1'b0;
    wd_ready   = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    done_valid = 1'b0;
    done_err   = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    WLAST      = 1'b0;
    BREADY     = 1'b0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    case (state)
      S_IDLE: begin
        // Gated so that every READY output reads 0 while reset is held.
        req_ready = ARESETn;
        if (req_valid) begin
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = req_write ? S_AW : S_AR;
        end
      end
      S_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nxt = S_W;
      end
      S_W: begin
        WVALID   = wd_valid;
        wd_ready = WREADY;
        WLAST    = last_cnt;
        if (wd_valid && WREADY) begin
          cnt_nxt = cnt + 1'b1;
          if (last_cnt) state_nxt = S_B;
        end
      end
      S_B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          err_nxt   = err | (BRESP != 2'b00) | (BID != MASTER_ID);
          state_nxt = S_DONE;
        end
      end
      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = S_R;
      end
      S_R: begin
        rd_valid = RVALID;
        RREADY   = rd_ready;
        rd_last  = RLAST;
        if (RVALID && rd_ready) begin
          cnt_nxt = cnt + 1'b1;
          // A missing RLAST at the expected beat or an early/late RLAST
          // both mark the transfer as erroneous; beats keep flowing until
          // the slave finally signals RLAST.
          err_nxt = err | (RRESP != 2'b00) | (RID != MASTER_ID)
                        | (last_cnt && !RLAST) | (RLAST && !last_cnt);
          if (RLAST) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_valid = 1'b1;
        done_err   = err;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_master_port.sv
// Directed testbench for axi_master_port: acts as client and AXI slave.
module tb_axi_master_port;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [2:0]  req_size;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done_valid, done_err;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int checks = 0;
  int failures = 0;

  axi_master_port dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_err(done_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_addr = '0; req_len = '0; req_size = '0;
    wd_valid = 0; wd_data = '0; wd_strb = '0; rd_ready = 0;
    AWREADY = 0; WREADY = 0; BID = '0; BRESP = '0; BVALID = 0;
    ARREADY = 0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
  endtask

  // Client+slave driver for one write; returns observations for the caller to judge.
  task automatic write_txn(input logic [31:0] a, input logic [3:0] l, input int awd,
                           input logic [1:0] bresp, input int stall_at, input int stall_n,
                           output int accepted, output int aw_bad, output int early_w,
                           output int beats, output int lastcnt, output int lastpos,
                           output int datbad, output int holdbad, output int bgot,
                           output logic dv, output logic de, output logic rr);
    int k, stalls;
    bit fin, hs;
    accepted = 0; aw_bad = 0; early_w = 0; beats = 0; lastcnt = 0; lastpos = 0;
    datbad = 0; holdbad = 0; bgot = 0; k = 0; stalls = 0; fin = 0;
    req_write = 1; req_addr = a; req_len = l; req_size = 3'd2; req_valid = 1;
    wd_valid = 1; wd_data = 32'hA000_0000; wd_strb = 4'h0;
    @(negedge ACLK); accepted = int'(req_ready);
    tick(); req_valid = 0;
    for (int i = 0; i <= awd; i++) begin
      AWREADY = (i == awd);
      @(negedge ACLK);
      if (!AWVALID || AWADDR !== a || AWLEN !== l || AWID !== 4'd0 ||
          AWBURST !== 2'b01 || AWSIZE !== 3'd2) aw_bad++;
      if (WVALID) early_w++;
      tick();
    end
    AWREADY = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      wd_data = 32'hA000_0000 + k; wd_strb = k[3:0];
      WREADY = !(k == stall_at && stalls < stall_n);
      @(negedge ACLK);
      if (AWVALID) aw_bad++;
      if (!WVALID) holdbad++;
      if (WVALID && !WREADY) stalls++;
      hs = WVALID && WREADY;
      if (hs) begin
        beats++;
        if (WDATA !== 32'hA000_0000 + k || WSTRB !== k[3:0]) datbad++;
        if (WLAST) begin lastcnt++; lastpos = beats; fin = 1; end
      end
      tick();
      if (hs) k++;
    end
    wd_valid = 0; WREADY = 0;
    BVALID = 1; BRESP = bresp; BID = 4'd0;
    for (int i = 0; i < 20 && bgot == 0; i++) begin
      @(negedge ACLK); if (BREADY) bgot = 1;
      tick();
    end
    BVALID = 0; BRESP = 0;
    @(negedge ACLK); dv = done_valid; de = done_err; rr = req_ready;
    tick();
  endtask

  // Client+slave driver for one read; slave sends nb beats with RLAST on the last.
  task automatic read_txn(input logic [31:0] a, input logic [3:0] l, input int nb,
                          input bit toggle, input int max_beats,
                          output int accepted, output int ar_bad, output int beats,
                          output int lastcnt, output int lastpos, output int datbad,
                          output logic dv, output logic de);
    int j;
    bit fin, hs;
    accepted = 0; ar_bad = 0; beats = 0; lastcnt = 0; lastpos = 0; datbad = 0;
    j = 0; fin = 0; dv = 0; de = 0;
    req_write = 0; req_addr = a; req_len = l; req_size = 3'd2; req_valid = 1;
    @(negedge ACLK); accepted = int'(req_ready);
    tick(); req_valid = 0;
    for (int i = 0; i <= 1; i++) begin
      ARREADY = (i == 1);
      @(negedge ACLK);
      if (!ARVALID || ARADDR !== a || ARLEN !== l || ARID !== 4'd0 || ARBURST !== 2'b01)
        ar_bad++;
      tick();
    end
    ARREADY = 0;
    for (int cyc = 0; cyc < 100 && !fin && beats < max_beats; cyc++) begin
      RVALID = 1; RDATA = 32'h5000_0000 + j; RLAST = (j == nb - 1); RRESP = 0; RID = 0;
      rd_ready = toggle ? cyc[0] : 1'b1;
      @(negedge ACLK);
      if (ARVALID || !rd_valid || RREADY !== rd_ready) ar_bad++;
      hs = rd_valid && rd_ready;
      if (hs) begin
        beats++;
        if (rd_data !== 32'h5000_0000 + j) datbad++;
        if (rd_last) begin lastcnt++; lastpos = beats; fin = 1; end
      end
      tick();
      if (hs) j++;
    end
    RVALID = 0; RLAST = 0; rd_ready = 0;
    if (fin) begin
      @(negedge ACLK); dv = done_valid; de = done_err;
      tick();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESETn = 0;
    #23;
    checks++;
    if ({req_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rd_valid, wd_ready, done_valid} !== 9'b0) begin
      failures++; $display("FAIL reset_outputs got=%b want=000000000",
        {req_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rd_valid, wd_ready, done_valid});
    end
    @(negedge ACLK); ARESETn = 1;
    @(negedge ACLK);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_idle_req_ready got=%b want=1", req_ready); end
    tick();
  endtask

  task automatic test_single_write();
    int acc, awb, ew, bt, lc, lp, db, hb, bg; logic dv, de, rr;
    write_txn(32'h1000_0000, 4'd0, 2, 2'b00, -1, 0, acc, awb, ew, bt, lc, lp, db, hb, bg, dv, de, rr);
    checks++; if (acc != 1) begin failures++; $display("FAIL sw_accept got=%0d want=1", acc); end
    checks++; if (awb != 0) begin failures++; $display("FAIL sw_aw_channel bad_cycles=%0d want=0", awb); end
    checks++; if (ew != 0) begin failures++; $display("FAIL sw_early_wvalid got=%0d want=0", ew); end
    checks++; if (bt != 1 || lc != 1 || lp != 1) begin failures++;
      $display("FAIL sw_beats beats=%0d lasts=%0d lastpos=%0d want=1/1/1", bt, lc, lp); end
    checks++; if (db != 0) begin failures++; $display("FAIL sw_wdata bad=%0d want=0", db); end
    checks++; if (bg != 1) begin failures++; $display("FAIL sw_bready got=%0d want=1", bg); end
    checks++; if (dv !== 1'b1 || de !== 1'b0 || rr !== 1'b0) begin failures++;
      $display("FAIL sw_done dv=%b de=%b req_ready=%b want=1/0/0", dv, de, rr); end
    @(negedge ACLK);
    checks++; if (done_valid !== 1'b0 || req_ready !== 1'b1) begin failures++;
      $display("FAIL sw_back_idle dv=%b req_ready=%b want=0/1", done_valid, req_ready); end
    tick();
  endtask

  task automatic test_read_burst();
    int acc, arb, bt, lc, lp, db; logic dv, de;
    read_txn(32'h0000_0100, 4'd3, 4, 1'b1, 10, acc, arb, bt, lc, lp, db, dv, de);
    checks++; if (acc != 1 || arb != 0) begin failures++;
      $display("FAIL rb_ar accept=%0d bad=%0d want=1/0", acc, arb); end
    checks++; if (bt != 4 || lc != 1 || lp != 4) begin failures++;
      $display("FAIL rb_beats beats=%0d lasts=%0d lastpos=%0d want=4/1/4", bt, lc, lp); end
    checks++; if (db != 0) begin failures++; $display("FAIL rb_rdata bad=%0d want=0", db); end
    checks++; if (dv !== 1'b1 || de !== 1'b0) begin failures++;
      $display("FAIL rb_done dv=%b de=%b want=1/0", dv, de); end
  endtask

  task automatic test_error_write();
    int acc, awb, ew, bt, lc, lp, db, hb, bg; logic dv, de, rr;
    write_txn(32'h2000_0040, 4'd1, 0, 2'b11, -1, 0, acc, awb, ew, bt, lc, lp, db, hb, bg, dv, de, rr);
    checks++; if (bt != 2 || lp != 2) begin failures++;
      $display("FAIL ew_beats beats=%0d lastpos=%0d want=2/2", bt, lp); end
    checks++; if (dv !== 1'b1 || de !== 1'b1) begin failures++;
      $display("FAIL ew_done dv=%b de=%b want=1/1", dv, de); end
    // Next request must be accepted and the error flag cleared.
    write_txn(32'h2000_0080, 4'd0, 1, 2'b00, -1, 0, acc, awb, ew, bt, lc, lp, db, hb, bg, dv, de, rr);
    checks++; if (acc != 1) begin failures++; $display("FAIL ew_next_accept got=%0d want=1", acc); end
    checks++; if (dv !== 1'b1 || de !== 1'b0) begin failures++;
      $display("FAIL ew_next_done dv=%b de=%b want=1/0", dv, de); end
  endtask

  task automatic test_early_rlast();
    int acc, arb, bt, lc, lp, db; logic dv, de;
    read_txn(32'h0000_0200, 4'd3, 2, 1'b0, 10, acc, arb, bt, lc, lp, db, dv, de);
    checks++; if (bt != 2 || lp != 2) begin failures++;
      $display("FAIL er_beats beats=%0d lastpos=%0d want=2/2", bt, lp); end
    checks++; if (dv !== 1'b1 || de !== 1'b1) begin failures++;
      $display("FAIL er_done dv=%b de=%b want=1/1", dv, de); end
  endtask

  task automatic test_burst_stall();
    int acc, awb, ew, bt, lc, lp, db, hb, bg; logic dv, de, rr;
    // Beat index 4 (the 5th beat) is held off by WREADY low for 3 cycles.
    write_txn(32'h3000_0000, 4'd15, 1, 2'b00, 4, 3, acc, awb, ew, bt, lc, lp, db, hb, bg, dv, de, rr);
    checks++; if (bt != 16 || lc != 1 || lp != 16) begin failures++;
      $display("FAIL bs_beats beats=%0d lasts=%0d lastpos=%0d want=16/1/16", bt, lc, lp); end
    checks++; if (hb != 0 || db != 0) begin failures++;
      $display("FAIL bs_hold wvalid_drops=%0d data_bad=%0d want=0/0", hb, db); end
    checks++; if (dv !== 1'b1 || de !== 1'b0) begin failures++;
      $display("FAIL bs_done dv=%b de=%b want=1/0", dv, de); end
  endtask

  task automatic test_reset_mid_read();
    int acc, arb, bt, lc, lp, db, seen; logic dv, de;
    read_txn(32'h0000_0400, 4'd7, 8, 1'b0, 3, acc, arb, bt, lc, lp, db, dv, de);
    checks++; if (bt != 3) begin failures++; $display("FAIL rm_pre_beats got=%0d want=3", bt); end
    // Slave still offering a beat when reset hits.
    RVALID = 1; RDATA = 32'h5000_0003; rd_ready = 1;
    #2 ARESETn = 0;
    #1;
    checks++;
    if ({req_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rd_valid, rd_last, done_valid} !== 9'b0) begin
      failures++; $display("FAIL rm_outputs got=%b want=000000000",
        {req_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rd_valid, rd_last, done_valid});
    end
    RVALID = 0; rd_ready = 0;
    @(negedge ACLK); ARESETn = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK); if (done_valid) seen++;
    end
    checks++; if (seen != 0 || req_ready !== 1'b1) begin failures++;
      $display("FAIL rm_idle done_pulses=%0d req_ready=%b want=0/1", seen, req_ready); end
    tick();
    read_txn(32'h0000_0500, 4'd1, 2, 1'b0, 10, acc, arb, bt, lc, lp, db, dv, de);
    checks++; if (bt != 2 || dv !== 1'b1 || de !== 1'b0) begin failures++;
      $display("FAIL rm_recover beats=%0d dv=%b de=%b want=2/1/0", bt, dv, de); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_error_write();
    test_early_rlast();
    test_burst_stall();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
